// File: rtl/sram_line_master.sv
// sram_line_master: splits one 64-bit cache line request into four paced 16-bit SRAM word accesses.
// Define SRAM_LINE_MASTER_WRAP_EN for critical-word-first ordering starting at req_addr[1:0].
module sram_line_master #(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [17:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic [63:0] rdata,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we,
    input  logic [15:0] SRAM_read_data
);
    localparam int CW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;

    if (ACCESS_CYCLES < 2) begin : g_bad_cfg
        $error("sram_line_master: ACCESS_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, GAP, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    widx_q, widx_d;
    logic [1:0]    wcnt_q, wcnt_d;
    logic          lwe_q, lwe_d;
    logic [15:0]   base_q, base_d;
    logic [63:0]   line_q, line_d;
    logic [63:0]   rdata_q, rdata_d;
    logic [17:0]   addr_q, addr_d;
    logic [15:0]   wd_q, wd_d;
    logic          we_q, we_d;
    logic          done_q, done_d;
    logic [1:0]    start_w;
    logic          last_w;

`ifdef SRAM_LINE_MASTER_WRAP_EN
    assign start_w = req_addr[1:0];
`else
    logic unused_lo;
    assign unused_lo = ^req_addr[1:0];
    assign start_w   = 2'd0;
`endif

    assign last_w = cnt_q == CW'(ACCESS_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            widx_q  <= '0;
            wcnt_q  <= '0;
            lwe_q   <= 1'b0;
            base_q  <= '0;
            line_q  <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            widx_q  <= widx_d;
            wcnt_q  <= wcnt_d;
            lwe_q   <= lwe_d;
            base_q  <= base_d;
            line_q  <= line_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        widx_d  = widx_q;
        wcnt_d  = wcnt_q;
        lwe_d   = lwe_q;
        base_d  = base_q;
        line_d  = line_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = ACCESS;
                lwe_d   = req_we;
                base_d  = req_addr[17:2];
                widx_d  = start_w;
                line_d  = req_wdata;
                cnt_d   = '0;
                wcnt_d  = '0;
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (last_w) begin
                    if (!lwe_q) rdata_d[{widx_q, 4'b0} +: 16] = SRAM_read_data;
                    state_d = (wcnt_q == 2'd3) ? DONE : GAP;
                end
            end
            GAP: begin
                widx_d  = widx_q + 1'b1;
                wcnt_d  = wcnt_q + 1'b1;
                cnt_d   = '0;
                state_d = ACCESS;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are computed from the upcoming state.
    always_comb begin
        addr_d = (state_d == ACCESS || state_d == GAP) ? {base_d, widx_d} : '0;
        we_d   = (state_d == ACCESS) && lwe_d;
        wd_d   = we_d ? line_d[{widx_d, 4'b0} +: 16] : '0;
        done_d = state_d == DONE;
    end

    assign busy            = state_q != IDLE;
    assign done            = done_q;
    assign rdata           = rdata_q;
    assign SRAM_address    = addr_q;
    assign SRAM_write_data = wd_q;
    assign SRAM_we         = we_q;
endmodule
